// File: rtl/mac_sequencer_if.sv
// Handshake bundle between the MAC sequencer and the signal/coefficient FIFOs.
// The slave modport is the sequencer's view; the master modport is the
// surrounding MAC top level (FIFO status, upstream valids, control pulses).
interface mac_sequencer_if #(
    parameter int ADDR_LINES = 4,
    parameter int CNT_W      = 16
);
    // Control and upstream requests
    logic                  cfg_start_i;
    logic                  stop_i;
    logic                  coeff_valid_i;
    logic                  coeff_last_i;
    logic                  signal_valid_i;

    // FIFO status
    logic                  full_coeff_i;
    logic                  full_signal_i;
    logic                  empty_signal_i;
    logic [ADDR_LINES-1:0] wr_ptr_coeff_i;

    // FIFO strobes
    logic                  wr_en_coeff_o;
    logic                  wr_en_signal_o;
    logic                  rd_en_coeff_o;
    logic                  rd_en_signal_o;

    // Datapath control and status
    logic                  redo_coeff_o;
    logic                  acc_clr_n_o;
    logic                  ld_result_o;
    logic                  busy_o;
    logic [ADDR_LINES:0]   taps_o;
    logic [CNT_W-1:0]      result_cnt_o;

    modport slave (
        input  cfg_start_i, stop_i, coeff_valid_i, coeff_last_i, signal_valid_i,
        input  full_coeff_i, full_signal_i, empty_signal_i, wr_ptr_coeff_i,
        output wr_en_coeff_o, wr_en_signal_o, rd_en_coeff_o, rd_en_signal_o,
        output redo_coeff_o, acc_clr_n_o, ld_result_o, busy_o, taps_o, result_cnt_o
    );

    modport master (
        output cfg_start_i, stop_i, coeff_valid_i, coeff_last_i, signal_valid_i,
        output full_coeff_i, full_signal_i, empty_signal_i, wr_ptr_coeff_i,
        input  wr_en_coeff_o, wr_en_signal_o, rd_en_coeff_o, rd_en_signal_o,
        input  redo_coeff_o, acc_clr_n_o, ld_result_o, busy_o, taps_o, result_cnt_o
    );
endinterface

// File: rtl/mac_sequencer.sv
// Control FSM for the MAC block. Gates writes into the signal and coefficient
// FIFOs, then runs one dot-product per output sample: N lock-step reads of both
// FIFOs, a PIPE_LAT-cycle drain, and a one-cycle result load. Between samples
// the coefficient FIFO is rewound and the accumulator cleared.
//
// FIFO strobes are combinational so a write/read lands in the same cycle as
// its request; every other output is registered and computed from the next
// state, so it is valid for exactly the cycles the FSM spends in that state.
module mac_sequencer #(
    parameter int ADDR_LINES = 4,
    parameter int PIPE_LAT   = 2,
    parameter int CNT_W      = 16
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    mac_sequencer_if.slave bus
);
    localparam int TAP_W = ADDR_LINES + 1;
    localparam int DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_ACCUM,
        S_DRAIN,
        S_LDRES
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [TAP_W-1:0] tap_cnt;
    logic [TAP_W-1:0] taps;
    logic [DRN_W-1:0] drain_cnt;
    logic [CNT_W-1:0] result_cnt;
    logic             stop_pend;

    logic             busy;
    logic             acc_clr_n;
    logic             redo;
    logic             ld_result;

    logic             stop_seen;
    logic             coeff_wr;
    logic             last_wr;
    logic             rd_en;
    logic             sig_wr_window;
    logic             last_tap;

    // ------------------------------------------------------------------
    // Combinational strobes
    // ------------------------------------------------------------------

    // A stop request counts whether it arrives this cycle or was latched earlier.
    assign stop_seen     = stop_pend | bus.stop_i;

    // Writes attempted while the target FIFO is full are simply dropped.
    assign coeff_wr      = (state == S_LOAD) & bus.coeff_valid_i & ~bus.full_coeff_i;
    assign last_wr       = coeff_wr & bus.coeff_last_i;
    assign sig_wr_window = (state == S_CLEAR) | (state == S_ACCUM) |
                           (state == S_DRAIN) | (state == S_LDRES);

    // Both FIFOs are read together; an empty signal FIFO stalls the sample.
    assign rd_en         = (state == S_ACCUM) & ~bus.empty_signal_i;
    assign last_tap      = (tap_cnt == taps - TAP_W'(1));

    assign bus.wr_en_coeff_o  = coeff_wr;
    assign bus.wr_en_signal_o = sig_wr_window & bus.signal_valid_i & ~bus.full_signal_i;
    assign bus.rd_en_coeff_o  = rd_en;
    assign bus.rd_en_signal_o = rd_en;

    assign bus.redo_coeff_o   = redo;
    assign bus.acc_clr_n_o    = acc_clr_n;
    assign bus.ld_result_o    = ld_result;
    assign bus.busy_o         = busy;
    assign bus.taps_o         = taps;
    assign bus.result_cnt_o   = result_cnt;

    // ------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------

    // Next-state logic for the sample sequence.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (bus.cfg_start_i) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                // stop wins over a simultaneous final-tap write
                if (stop_seen)    state_nxt = S_IDLE;
                else if (last_wr) state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                state_nxt = stop_seen ? S_IDLE : S_ACCUM;
            end
            S_ACCUM: begin
                if (rd_en && last_tap) state_nxt = (PIPE_LAT == 0) ? S_LDRES : S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_cnt == DRN_W'(PIPE_LAT - 1)) state_nxt = S_LDRES;
            end
            S_LDRES: begin
                state_nxt = S_CLEAR;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, counters and registered outputs
    // ------------------------------------------------------------------

    // Advance the FSM and register every output that is a function of state.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= S_IDLE;
            tap_cnt    <= '0;
            taps       <= '0;
            drain_cnt  <= '0;
            result_cnt <= '0;
            stop_pend  <= 1'b0;
            busy       <= 1'b0;
            acc_clr_n  <= 1'b0;
            redo       <= 1'b0;
            ld_result  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= state_nxt;

            // Latched stop request, dropped once the FSM is back in IDLE.
            stop_pend <= (state_nxt == S_IDLE) ? 1'b0 : stop_seen;

            busy      <= (state_nxt != S_IDLE);
            acc_clr_n <= (state_nxt == S_ACCUM) | (state_nxt == S_DRAIN) |
                         (state_nxt == S_LDRES);
            redo      <= (state_nxt == S_CLEAR);
            ld_result <= (state_nxt == S_LDRES);

            // Result count restarts with each configuration and wraps freely.
            if (state == S_IDLE && bus.cfg_start_i) begin
                result_cnt <= '0;
            end else if (state_nxt == S_LDRES) begin
                result_cnt <= result_cnt + CNT_W'(1);
            end

            // Tap count is the write pointer of the final tap plus one, so a
            // full FIFO (pointer all-ones) yields 2**ADDR_LINES without wrap.
            if (state == S_LOAD && last_wr && !stop_seen) begin
                taps <= {1'b0, bus.wr_ptr_coeff_i} + TAP_W'(1);
            end

            if (state_nxt == S_CLEAR) begin
                tap_cnt <= '0;
            end else if (rd_en) begin
                tap_cnt <= tap_cnt + TAP_W'(1);
            end

            if (state == S_DRAIN) begin
                drain_cnt <= drain_cnt + DRN_W'(1);
            end else begin
                drain_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer (ADDR_LINES=4, PIPE_LAT=2, CNT_W=16).
// Inputs change 1 ns after the rising edge; outputs are compared 1-2 ns later.
module tb_mac_sequencer;
    localparam int ADDR_LINES = 4;
    localparam int PIPE_LAT   = 2;
    localparam int CNT_W      = 16;

    logic clk_i;
    logic rstn_i;
    int   tests_run;
    int   tests_failed;

    mac_sequencer_if #(.ADDR_LINES(ADDR_LINES), .CNT_W(CNT_W)) bus ();

    mac_sequencer #(
        .ADDR_LINES (ADDR_LINES),
        .PIPE_LAT   (PIPE_LAT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .bus    (bus.slave)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Control outputs packed as {busy, acc_clr_n, redo, ld, rd_c, rd_s, wr_c, wr_s}
    function automatic logic [7:0] ctl();
        return {bus.busy_o, bus.acc_clr_n_o, bus.redo_coeff_o, bus.ld_result_o,
                bus.rd_en_coeff_o, bus.rd_en_signal_o, bus.wr_en_coeff_o, bus.wr_en_signal_o};
    endfunction

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        bus.cfg_start_i    = 1'b0;
        bus.stop_i         = 1'b0;
        bus.coeff_valid_i  = 1'b0;
        bus.coeff_last_i   = 1'b0;
        bus.signal_valid_i = 1'b0;
        bus.full_coeff_i   = 1'b0;
        bus.full_signal_i  = 1'b0;
        bus.empty_signal_i = 1'b0;
        bus.wr_ptr_coeff_i = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rstn_i = 1'b0;
        cyc();
        cyc();
        rstn_i = 1'b1;
    endtask

    // From IDLE (or LOAD, where the start pulse is ignored): write n coefficients,
    // the last flagged. Returns 1 ns after the edge that enters CLEAR.
    task automatic load_coeffs(input int n);
        bus.cfg_start_i = 1'b1;
        cyc();
        bus.cfg_start_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.coeff_valid_i  = 1'b1;
            bus.coeff_last_i   = (i == n - 1);
            bus.wr_ptr_coeff_i = ADDR_LINES'(i);
            #1;
            tests_run++;
            if (bus.wr_en_coeff_o !== 1'b1) begin
                tests_failed++;
                $display("FAIL load wr_en_coeff i=%0d: got %b expected 1", i, bus.wr_en_coeff_o);
            end
            cyc();
        end
        bus.coeff_valid_i = 1'b0;
        bus.coeff_last_i  = 1'b0;
    endtask

    // Reset state, then reset asserted in the middle of ACCUM.
    task automatic test_reset();
        clear_inputs();
        rstn_i = 1'b0;
        #2;
        tests_run++;
        if (ctl() !== 8'b0000_0000 || bus.taps_o !== 5'd0 || bus.result_cnt_o !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_initial: got ctl=%b taps=%0d cnt=%0d expected ctl=00000000 taps=0 cnt=0",
                     ctl(), bus.taps_o, bus.result_cnt_o);
        end
        do_reset();
        load_coeffs(4);
        cyc();
        cyc();
        tests_run++;
        if (ctl() !== 8'b1100_1100) begin
            tests_failed++;
            $display("FAIL reset_pre_accum: got %b expected 11001100", ctl());
        end
        bus.signal_valid_i = 1'b1;
        rstn_i = 1'b0;
        #1;
        tests_run++;
        if (ctl() !== 8'b0000_0000 || bus.taps_o !== 5'd0 || bus.result_cnt_o !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_accum: got ctl=%b taps=%0d cnt=%0d expected ctl=00000000 taps=0 cnt=0",
                     ctl(), bus.taps_o, bus.result_cnt_o);
        end
        cyc();
        cyc();
        clear_inputs();
        rstn_i = 1'b1;
        cyc();
        tests_run++;
        if (ctl() !== 8'b0000_0000) begin
            tests_failed++;
            $display("FAIL reset_release_idle: got %b expected 00000000", ctl());
        end
    endtask

    // Four-tap load, single CLEAR cycle with one redo pulse.
    task automatic test_load();
        do_reset();
        bus.empty_signal_i = 1'b1;
        load_coeffs(4);
        tests_run++;
        if (bus.taps_o !== 5'd4 || ctl() !== 8'b1010_0000) begin
            tests_failed++;
            $display("FAIL load_clear: got taps=%0d ctl=%b expected taps=4 ctl=10100000", bus.taps_o, ctl());
        end
        for (int c = 0; c < 2; c++) begin
            cyc();
            tests_run++;
            if (ctl() !== 8'b1100_0000) begin
                tests_failed++;
                $display("FAIL load_accum_stall c=%0d: got %b expected 11000000", c, ctl());
            end
        end
    endtask

    // Steady state with a never-empty signal FIFO: 8 cycles per result.
    task automatic test_stream();
        logic rd, ld, redo;
        do_reset();
        load_coeffs(4);
        for (int c = 0; c < 16; c++) begin
            cyc();
            rd   = (c % 8) < 4;
            ld   = (c % 8) == 6;
            redo = (c % 8) == 7;
            tests_run++;
            if (ctl() !== {1'b1, ~redo, redo, ld, rd, rd, 2'b00}) begin
                tests_failed++;
                $display("FAIL stream c=%0d: got %b expected %b", c, ctl(),
                         {1'b1, ~redo, redo, ld, rd, rd, 2'b00});
            end
        end
        tests_run++;
        if (bus.result_cnt_o !== 16'd2) begin
            tests_failed++;
            $display("FAIL stream_result_cnt: got %0d expected 2", bus.result_cnt_o);
        end
        bus.signal_valid_i = 1'b1;
        #1;
        tests_run++;
        if (bus.wr_en_signal_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL stream_sig_write: got %b expected 1", bus.wr_en_signal_o);
        end
        bus.signal_valid_i = 1'b0;
    endtask

    // Signal FIFO empty for 5 cycles after the second read.
    task automatic test_stall();
        logic rd, ld, redo;
        int   ld_count;
        do_reset();
        load_coeffs(4);
        ld_count = 0;
        for (int c = 0; c < 13; c++) begin
            cyc();
            bus.empty_signal_i = (c >= 2 && c <= 6);
            #1;
            rd   = (c <= 1) || (c == 7) || (c == 8);
            ld   = (c == 11);
            redo = (c == 12);
            if (bus.ld_result_o === 1'b1) ld_count++;
            tests_run++;
            if (ctl() !== {1'b1, ~redo, redo, ld, rd, rd, 2'b00}) begin
                tests_failed++;
                $display("FAIL stall c=%0d: got %b expected %b", c, ctl(),
                         {1'b1, ~redo, redo, ld, rd, rd, 2'b00});
            end
            if (c == 6) begin
                tests_run++;
                if (dut.tap_cnt !== 5'd2) begin
                    tests_failed++;
                    $display("FAIL stall_tap_hold: got %0d expected 2", dut.tap_cnt);
                end
            end
        end
        tests_run++;
        if (ld_count !== 1) begin
            tests_failed++;
            $display("FAIL stall_ld_count: got %0d expected 1", ld_count);
        end
    endtask

    // Dropped writes when full, and a full 16-tap load.
    task automatic test_full();
        do_reset();
        bus.cfg_start_i = 1'b1;
        cyc();
        bus.cfg_start_i    = 1'b0;
        bus.signal_valid_i = 1'b1;
        bus.coeff_valid_i  = 1'b1;
        bus.coeff_last_i   = 1'b1;
        bus.full_coeff_i   = 1'b1;
        bus.wr_ptr_coeff_i = 4'd5;
        #1;
        tests_run++;
        if (bus.wr_en_coeff_o !== 1'b0 || bus.wr_en_signal_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_coeff_drop: got wr_c=%b wr_s=%b expected 0 0",
                     bus.wr_en_coeff_o, bus.wr_en_signal_o);
        end
        cyc();
        bus.coeff_valid_i = 1'b0;
        bus.coeff_last_i  = 1'b0;
        bus.full_coeff_i  = 1'b0;
        tests_run++;
        if (ctl() !== 8'b1000_0000 || bus.taps_o !== 5'd0) begin
            tests_failed++;
            $display("FAIL full_stay_load: got ctl=%b taps=%0d expected ctl=10000000 taps=0", ctl(), bus.taps_o);
        end
        load_coeffs(16);
        tests_run++;
        if (bus.taps_o !== 5'd16) begin
            tests_failed++;
            $display("FAIL taps16: got %0d expected 16", bus.taps_o);
        end
        bus.full_signal_i = 1'b1;
        #1;
        tests_run++;
        if (bus.wr_en_signal_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_signal_drop: got %b expected 0", bus.wr_en_signal_o);
        end
        bus.full_signal_i = 1'b0;
        #1;
        tests_run++;
        if (bus.wr_en_signal_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL signal_write_clear: got %b expected 1", bus.wr_en_signal_o);
        end
        bus.signal_valid_i = 1'b0;
    endtask

    // stop during ACCUM completes the sample; cfg_start mid-sample is ignored;
    // stop together with the final tap write in LOAD returns to IDLE.
    task automatic test_stop();
        logic busy, acc, redo, ld, rd;
        do_reset();
        load_coeffs(4);
        for (int c = 0; c < 10; c++) begin
            cyc();
            bus.stop_i      = (c == 1);
            bus.cfg_start_i = (c == 1) || (c == 2);
            #1;
            busy = (c <= 7);
            acc  = (c <= 6);
            redo = (c == 7);
            ld   = (c == 6);
            rd   = (c <= 3);
            tests_run++;
            if (ctl() !== {busy, acc, redo, ld, rd, rd, 2'b00}) begin
                tests_failed++;
                $display("FAIL stop c=%0d: got %b expected %b", c, ctl(),
                         {busy, acc, redo, ld, rd, rd, 2'b00});
            end
            if (c == 6) begin
                tests_run++;
                if (bus.result_cnt_o !== 16'd1) begin
                    tests_failed++;
                    $display("FAIL stop_result_cnt: got %0d expected 1", bus.result_cnt_o);
                end
            end
        end
        bus.cfg_start_i = 1'b1;
        cyc();
        bus.cfg_start_i    = 1'b0;
        bus.coeff_valid_i  = 1'b1;
        bus.coeff_last_i   = 1'b1;
        bus.wr_ptr_coeff_i = 4'd7;
        bus.stop_i         = 1'b1;
        cyc();
        clear_inputs();
        #1;
        tests_run++;
        if (ctl() !== 8'b0000_0000 || bus.taps_o !== 5'd4) begin
            tests_failed++;
            $display("FAIL stop_wins_load: got ctl=%b taps=%0d expected ctl=00000000 taps=4", ctl(), bus.taps_o);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_load();
        test_stream();
        test_stall();
        test_full();
        test_stop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
